// File: rtl/exp_pipe_pkg.sv
// Shared widths, FSM encoding and a constant-evaluable clog2 for the exp-pipe front-end.
package exp_pipe_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned RES_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or above rr_ptr (wrapping) wins;
// the pointer moves one past the winner after every grant.
module rr_arbiter
    import exp_pipe_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gnt_en,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] k;
    logic            found;

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        k      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[k]) begin
                found  = 1'b1;
                gnt_id = k;
            end
        end
        gnt_any = gnt_en & found;
        gnt     = '0;
        if (gnt_any) gnt[gnt_id] = 1'b1;
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = ID_W'((32'(gnt_id) + 1) % NUM_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/exp_pipe_arbiter.sv
// Shares one x^8 pipeline among NUM_REQ requesters: round-robin issue, requester-ID
// delay line matched to the pipeline latency, response routing and enable/drain control.
module exp_pipe_arbiter
    import exp_pipe_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    pipe_i_valid,
    output logic [OP_W-1:0]         pipe_i_data,
    input  logic                    pipe_o_valid,
    input  logic [RES_W-1:0]        pipe_o_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned ID_W  = clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(LATENCY + 3);

    state_e                        state_q, state_d;
    logic   [NUM_REQ-1:0]          gnt;
    logic   [ID_W-1:0]             gnt_id;
    logic                          hs;
    logic                          rsp_ld;

    logic                          pipe_i_valid_q, pipe_i_valid_d;
    logic   [OP_W-1:0]             pipe_i_data_q, pipe_i_data_d;
    logic   [LATENCY:0]            tag_vld_q, tag_vld_d;
    logic   [LATENCY:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic   [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic   [RES_W-1:0]            rsp_data_q, rsp_data_d;
    logic   [CNT_W-1:0]            cnt_q, cnt_d;
    logic                          err_q, err_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt_en    (state_q == ST_RUN),
        .req_valid (req_valid),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_any   (hs)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en)            state_d = ST_RUN;
            ST_RUN:   if (!en)           state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0)   state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Stage LATENCY of the tag line lines up with the pipeline's o_valid.
    assign rsp_ld = pipe_o_valid & tag_vld_q[LATENCY];

    always_comb begin
        pipe_i_valid_d = hs;
        pipe_i_data_d  = hs ? req_data[32'(gnt_id) * OP_W +: OP_W] : pipe_i_data_q;
        tag_vld_d      = {tag_vld_q[LATENCY-1:0], hs};
        tag_id_d       = {tag_id_q[LATENCY-1:0], gnt_id};
        rsp_valid_d    = rsp_ld ? (NUM_REQ'(1) << tag_id_q[LATENCY]) : '0;
        rsp_data_d     = rsp_ld ? pipe_o_data : rsp_data_q;
        cnt_d          = cnt_q;
        if (hs && !rsp_ld)      cnt_d = cnt_q + CNT_W'(1);
        else if (!hs && rsp_ld) cnt_d = cnt_q - CNT_W'(1);
        err_d          = err_q | (pipe_o_valid ^ tag_vld_q[LATENCY]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pipe_i_valid_q <= 1'b0;
            pipe_i_data_q  <= '0;
            tag_vld_q      <= '0;
            tag_id_q       <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pipe_i_valid_q <= pipe_i_valid_d;
            pipe_i_data_q  <= pipe_i_data_d;
            tag_vld_q      <= tag_vld_d;
            tag_id_q       <= tag_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
        end
    end

    assign req_ready    = gnt;
    assign pipe_i_valid = pipe_i_valid_q;
    assign pipe_i_data  = pipe_i_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = (state_q != ST_IDLE) || (cnt_q != '0);
    assign err          = err_q;

endmodule

// File: tb/tb_exp_pipe_arbiter.sv
// Bench for exp_pipe_arbiter: stub x^8 pipeline, transaction-level reference model,
// a grant vector table and directed drain / wrap / error / reset sequences.
module tb_exp_pipe_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 3;
    localparam int unsigned OPW     = 7;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*OPW-1:0] req_data = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   pipe_i_valid;
    logic [OPW-1:0]         pipe_i_data;
    logic                   pipe_o_valid;
    logic [63:0]            pipe_o_data;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [63:0]            rsp_data;
    logic                   busy;
    logic                   err;
    logic                   inject = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    exp_pipe_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .pipe_i_valid (pipe_i_valid),
        .pipe_i_data  (pipe_i_data),
        .pipe_o_valid (pipe_o_valid),
        .pipe_o_data  (pipe_o_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err          (err)
    );

    function automatic logic [63:0] pow8(input logic [6:0] x);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < 8; i++) p = p * 64'(x);
        return p;
    endfunction

    // Stub pipeline: LAT-stage delay of x^8; inject forces a spurious o_valid.
    logic [LAT-1:0] stub_v;
    logic [63:0]    stub_d [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_v <= '0;
            for (int i = 0; i < LAT; i++) stub_d[i] <= '0;
        end else begin
            stub_v    <= {stub_v[LAT-2:0], pipe_i_valid};
            stub_d[0] <= pow8(pipe_i_data);
            for (int i = 1; i < LAT; i++) stub_d[i] <= stub_d[i-1];
        end
    end
    assign pipe_o_valid = stub_v[LAT-1] | inject;
    assign pipe_o_data  = stub_d[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, ":pipe_i_valid"}, 64'(pipe_i_valid), 64'd0);
        chk({tag, ":pipe_i_data"}, 64'(pipe_i_data), 64'd0);
        chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ":rsp_data"}, rsp_data, 64'd0);
        chk({tag, ":busy"}, 64'(busy), 64'd0);
        chk({tag, ":err"}, 64'(err), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: transactions queued with the cycle their response must appear.
    typedef struct {
        int          due;
        int          id;
        logic [63:0] res;
    } exp_t;

    exp_t               q[$];
    exp_t               e;
    exp_t               drop;
    int                 mst;     // 0 idle, 1 run, 2 drain
    int                 mptr;
    int                 gk;
    logic               merr;
    logic               mpiv;
    logic [OPW-1:0]     mpid;
    logic [63:0]        mrd;
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] erv;
    int                 rsp_cnt [NUM_REQ];
    int                 gnt_cnt [NUM_REQ];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                mst  = 0;
                mptr = 0;
                merr = 1'b0;
                mpiv = 1'b0;
                mpid = '0;
                mrd  = '0;
            end else begin
                cyc++;
                erv = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    erv  = NUM_REQ'(1) << q[0].id;
                    mrd  = q[0].res;
                    drop = q.pop_front();
                end
                chk("rsp_valid", 64'(rsp_valid), 64'(erv));
                chk("rsp_data", rsp_data, mrd);
                chk("pipe_i_valid", 64'(pipe_i_valid), 64'(mpiv));
                chk("pipe_i_data", 64'(pipe_i_data), 64'(mpid));
                chk("busy", 64'(busy), 64'(mst != 0 || q.size() != 0));
                chk("err", 64'(err), 64'(merr));
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (rsp_valid[k]) rsp_cnt[k]++;
                    if (req_ready[k]) gnt_cnt[k]++;
                end

                gk = -1;
                if (mst == 1) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gk < 0 && req_valid[(mptr + i) % NUM_REQ]) gk = (mptr + i) % NUM_REQ;
                    end
                end
                eg = '0;
                if (gk >= 0) eg = NUM_REQ'(1) << gk;
                chk("req_ready", 64'(req_ready), 64'(eg));

                if (inject && !(q.size() > 0 && q[0].due == cyc + 1)) merr = 1'b1;
                mpiv = (gk >= 0);
                if (gk >= 0) begin
                    mpid  = req_data[gk*OPW +: OPW];
                    e.due = cyc + 2 + LAT;
                    e.id  = gk;
                    e.res = pow8(mpid);
                    q.push_back(e);
                    mptr  = (gk + 1) % NUM_REQ;
                end
                case (mst)
                    0: if (en) mst = 1;
                    1: if (!en) mst = 2;
                    default: if (q.size() == 0) mst = 0;
                endcase
            end
        end
    end

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [NUM_REQ-1:0] ready;
    } vec_t;

    vec_t tbl [12];
    int   last_rsp;
    int   fell;
    int   seen;

    initial begin : main
        // Grant sequence from rr_ptr=0, one handshake per non-empty row.
        tbl[0]  = '{4'b0001, 4'b0001};
        tbl[1]  = '{4'b0001, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0010};
        tbl[3]  = '{4'b1111, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b1000};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b1010, 4'b1000};
        tbl[7]  = '{4'b0000, 4'b0000};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b0100, 4'b0100};
        tbl[11] = '{4'b0011, 4'b0001};
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_cnt[k] = 0;
            gnt_cnt[k] = 0;
        end

        #1;
        chk_zero("reset");
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        req_data = {7'd13, 7'd12, 7'd11, 7'd10};
        tick();

        foreach (tbl[i]) begin
            req_valid = tbl[i].rv;
            @(negedge clk);
            chk("tbl_ready", 64'(req_ready), 64'(tbl[i].ready));
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        // Single requester streaming 0..99.
        for (int k = 0; k < NUM_REQ; k++) rsp_cnt[k] = 0;
        for (int i = 0; i < 100; i++) begin
            req_valid   = 4'b0001;
            req_data[6:0] = 7'(i);
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        chk("stream_rsp_count", 64'(rsp_cnt[0]), 64'd100);

        // All four requesters continuously: fair rotation.
        req_data = {7'd13, 7'd12, 7'd11, 7'd10};
        for (int k = 0; k < NUM_REQ; k++) begin
            rsp_cnt[k] = 0;
            gnt_cnt[k] = 0;
        end
        req_valid = 4'b1111;
        repeat (40) tick();
        req_valid = '0;
        repeat (8) tick();
        for (int k = 0; k < NUM_REQ; k++) begin
            chk("fair_grants", 64'(gnt_cnt[k]), 64'd10);
            chk("fair_rsps", 64'(rsp_cnt[k]), 64'd10);
        end

        // Drain with three in flight.
        rsp_cnt[0] = 0;
        repeat (3) begin
            req_valid = 4'b0001;
            tick();
        end
        en = 1'b0;
        req_valid = '0;
        tick();
        req_valid = 4'b0001;
        last_rsp = -1;
        fell = -1;
        for (int i = 0; i < 20 && fell < 0; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) last_rsp = i;
            if (!busy) fell = i;
            else chk("drain_no_ready", 64'(req_ready), 64'd0);
            tick();
        end
        chk("drain_busy_fall", 64'(fell), 64'(last_rsp + 1));
        chk("drain_rsp_count", 64'(rsp_cnt[0]), 64'd3);
        req_valid = '0;

        // Pointer wrap: req 3 then req 0 (ptr sits at 1 here).
        en = 1'b1;
        tick();
        req_data = {7'd2, 7'd0, 7'd0, 7'd99};
        req_valid = 4'b1000;
        @(negedge clk);
        chk("wrap_gnt3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("wrap_gnt0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1;
            else tick();
        end
        chk("wrap_rsp3", 64'(rsp_valid), 64'b1000);
        chk("wrap_data3", rsp_data, 64'd256);
        tick();
        @(negedge clk);
        chk("wrap_rsp0", 64'(rsp_valid), 64'b0001);
        chk("wrap_data0", rsp_data, 64'd9227446944279201);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 19) != 0);
            req_valid = NUM_REQ'($urandom);
            req_data  = (NUM_REQ*OPW)'($urandom);
            tick();
        end
        en = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 40 && busy; i++) tick();
        @(negedge clk);
        chk("idle_after_random", 64'(busy), 64'd0);
        tick();

        // Spurious pipeline valid with no tag: sticky err.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        repeat (5) tick();
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("err_reset");
        tick();
        rst_n = 1'b1;

        // Reset with two requests in flight.
        en = 1'b1;
        tick();
        req_data = {7'd5, 7'd6, 7'd7, 7'd8};
        req_valid = 4'b0010;
        repeat (2) tick();
        req_valid = '0;
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) rsp_cnt[k] = 0;
        repeat (10) tick();
        chk("midrst_no_rsp", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 64'd0);
        @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
